// File: rtl/dma_sched.sv
// ----------------------------------------------------------------------------
// dma_sched
//   Schedules the single-port main-memory DMA port shared by the CNN
//   accelerator requesters (weight load, ifmap load, ofmap writeback, ...).
//   Only one requester is granted at a time, and the memory port carries one
//   word per cycle. Read words are streamed back tagged with the requester id.
//   Write words are pulled with a valid/ready handshake.
//
//   Build option:
//     DMA_SCHED_FIXED_PRIO_EN  defined   -> the lowest-index pending requester
//                                           always wins, and no pointer is kept
//                              undefined -> round-robin from a pointer that
//                                           advances past each finished owner
//
//   Ports:
//     clk, rst_n                clock (rising edge), async active-low reset
//     req / req_rw              per-requester request level and direction
//                               (1 = read memory)
//     req_addr / req_len        per-requester burst base address and length
//                               (packed slices)
//     grant / done              one-hot owner for the whole transfer;
//                               one-cycle completion pulse
//     mem_en/mem_rw/mem_addr    memory strobe, direction and word address
//     mem_wdata / mem_rdata     memory write data (equals wr_data) and
//                               read data
//     rd_valid/rd_data/rd_id    read word stream back to the requesters
//     wr_data/wr_valid/wr_ready write word handshake from the granted
//                               requester
// ----------------------------------------------------------------------------
module dma_sched #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int NUM_REQ    = 3,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic                          mem_en,
    output logic                          mem_rw,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [ID_W-1:0]               rd_id,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [LEN_WIDTH:0] CNT_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [ID_W-1:0]       id_r;
    logic [ID_W-1:0]       id_nxt_s;
    logic [ID_W-1:0]       win_s;
    logic                  rw_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH:0]    cnt_r;
    logic                  any_req_s;
    logic                  start_s;
    logic                  xfer_s;
    logic                  rd_issue_s;
    logic                  wr_accept_s;
    logic                  last_s;
    logic [NUM_REQ-1:0]    grant_r;
    logic [NUM_REQ-1:0]    done_r;
    logic                  rd_valid_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic [ID_W-1:0]       rd_id_r;

    logic [ADDR_WIDTH-1:0] addr_arr_s [NUM_REQ];
    logic [LEN_WIDTH-1:0]  len_arr_s  [NUM_REQ];

    // Decode a requester index into its one-hot grant/done position.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = {NUM_REQ{1'b0}};
        v[id] = 1'b1;
        return v;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_arr_s[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign len_arr_s[g]  = req_len[g*LEN_WIDTH +: LEN_WIDTH];
    end

    assign any_req_s   = |req;
    assign start_s     = (state_r == ST_IDLE) && any_req_s;
    assign xfer_s      = (state_r == ST_XFER);
    assign rd_issue_s  = xfer_s & rw_r;
    assign wr_accept_s = xfer_s & ~rw_r & wr_valid;
    // The counter is one bit wider than len, so len = 2^LEN_WIDTH-1 cannot overflow it.
    assign last_s      = ((cnt_r + CNT_ONE) == {1'b0, len_r});

    // The memory port is driven combinationally from the registered burst
    // state. A write strobe depends on wr_valid in the same cycle.
    assign mem_en    = rd_issue_s | wr_accept_s;
    assign mem_rw    = rd_issue_s;
    assign mem_addr  = xfer_s ? (base_r + ADDR_WIDTH'(cnt_r)) : {ADDR_WIDTH{1'b0}};
    assign mem_wdata = wr_data;
    assign wr_ready  = xfer_s & ~rw_r;

    assign grant    = grant_r;
    assign done     = done_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign rd_id    = rd_id_r;

`ifdef DMA_SCHED_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest pending index is written last.
    always_comb begin
        win_s = {ID_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_s = ID_W'(i);
            end else begin
                win_s = win_s;
            end
        end
    end
`else
    logic [ID_W-1:0] ptr_r;
    logic            found_s;
    int              idx_s;

    // Round-robin: the first pending requester at or after the pointer wins.
    always_comb begin
        win_s   = {ID_W{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = int'(ptr_r) + i;
            if (idx_s >= NUM_REQ) begin
                idx_s = idx_s - NUM_REQ;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s]) begin
                win_s   = ID_W'(idx_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // The pointer moves to the requester after the one that just finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {ID_W{1'b0}};
        end else if (state_r == ST_DONE) begin
            ptr_r <= (id_r == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (id_r + ID_W'(1));
        end
    end
`endif

    // Next-state logic. The winner's own length chooses between a burst and an immediate DONE.
    always_comb begin
        state_nxt_s = state_r;
        id_nxt_s    = id_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    id_nxt_s = win_s;
                    if (len_arr_s[win_s] != {LEN_WIDTH{1'b0}}) begin
                        state_nxt_s = ST_XFER;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (rw_r) begin
                    if (last_s) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_XFER;
                    end
                end else begin
                    if (wr_accept_s && last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_XFER;
                    end
                end
            end
            ST_FLUSH: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Burst registers, grant/done outputs registered from the next state, and the read return path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            id_r       <= {ID_W{1'b0}};
            rw_r       <= 1'b0;
            base_r     <= {ADDR_WIDTH{1'b0}};
            len_r      <= {LEN_WIDTH{1'b0}};
            cnt_r      <= {(LEN_WIDTH+1){1'b0}};
            grant_r    <= {NUM_REQ{1'b0}};
            done_r     <= {NUM_REQ{1'b0}};
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            rd_id_r    <= {ID_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            id_r    <= id_nxt_s;
            if (start_s) begin
                rw_r   <= req_rw[win_s];
                base_r <= addr_arr_s[win_s];
                len_r  <= len_arr_s[win_s];
                cnt_r  <= {(LEN_WIDTH+1){1'b0}};
            end else if (rd_issue_s || wr_accept_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            grant_r <= ((state_nxt_s == ST_XFER) || (state_nxt_s == ST_FLUSH)) ?
                       onehot(id_nxt_s) : {NUM_REQ{1'b0}};
            done_r  <= (state_nxt_s == ST_DONE) ? onehot(id_nxt_s) : {NUM_REQ{1'b0}};
            // mem_rdata is sampled on the edge that ends the read strobe cycle.
            rd_valid_r <= rd_issue_s;
            if (rd_issue_s) begin
                rd_data_r <= mem_rdata;
                rd_id_r   <= id_r;
            end
        end
    end

endmodule

// File: tb/tb_dma_sched.sv
module tb_dma_sched;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int NR = 3;
    localparam int IW = 2;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR-1:0]    req_rw;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    done;
    logic             mem_en;
    logic             mem_rw;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic             rd_valid;
    logic [DW-1:0]    rd_data;
    logic [IW-1:0]    rd_id;
    logic [DW-1:0]    wr_data;
    logic             wr_valid;
    logic             wr_ready;

    dma_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_len(req_len), .grant(grant), .done(done), .mem_en(mem_en), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready)
    );

    // Memory model: read data equals the low bits of the address.
    assign mem_rdata = mem_addr[DW-1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] st_cyc[$];
    logic [31:0] st_addr[$];
    logic [31:0] st_rw[$];
    logic [31:0] st_wd[$];
    logic [31:0] rd_cyc[$];
    logic [31:0] rd_dat[$];
    logic [31:0] rd_idq[$];
    logic [31:0] dn_cyc[$];
    logic [31:0] dn_vec[$];
    logic [31:0] gr_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_rw[i]          = rw;
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
    endtask

    // Cycle 0 is the cycle in which the caller has just raised req.
    task automatic run(input int ncyc, input logic [31:0] wv, input bit drop);
        logic [NR-1:0] dn_now;
        st_cyc.delete(); st_addr.delete(); st_rw.delete(); st_wd.delete();
        rd_cyc.delete(); rd_dat.delete(); rd_idq.delete();
        dn_cyc.delete(); dn_vec.delete(); gr_log.delete();
        wr_valid = wv[0];
        wr_data  = 16'hA000;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            dn_now = done;
            gr_log.push_back(32'(grant));
            if (mem_en) begin
                st_cyc.push_back(c); st_addr.push_back(32'(mem_addr));
                st_rw.push_back(32'(mem_rw)); st_wd.push_back(32'(mem_wdata));
            end
            if (rd_valid) begin
                rd_cyc.push_back(c); rd_dat.push_back(32'(rd_data)); rd_idq.push_back(32'(rd_id));
            end
            if (done != 3'b000) begin
                dn_cyc.push_back(c); dn_vec.push_back(32'(done));
            end
            @(posedge clk);
            #1;
            if (drop) req = req & ~dn_now;
            wr_valid = wv[c+1];
            wr_data  = 16'hA000 + 16'(c + 1);
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: read len 4 from 0x10
        set_req(0, 1'b1, 20'h00010, 8'd4);
        req = 3'b001;
        run(9, 32'h0, 1'b1);
        check("t1_nstrobe", st_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < st_cyc.size()) begin
                check("t1_st_cyc", st_cyc[i], i + 1);
                check("t1_st_addr", st_addr[i], 32'h10 + i);
                check("t1_st_rw", st_rw[i], 1);
            end
        end
        check("t1_nrd", rd_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_cyc.size()) begin
                check("t1_rd_cyc", rd_cyc[i], i + 2);
                check("t1_rd_data", rd_dat[i], 32'h10 + i);
                check("t1_rd_id", rd_idq[i], 0);
            end
        end
        check("t1_ndone", dn_cyc.size(), 1);
        if (dn_cyc.size() > 0) begin
            check("t1_done_cyc", dn_cyc[0], 6);
            check("t1_done_vec", dn_vec[0], 32'h1);
        end
        check("t1_grant_c0", gr_log[0], 32'h0);
        check("t1_grant_c1", gr_log[1], 32'h1);
        check("t1_grant_c6", gr_log[6], 32'h0);

        // T2: write len 3 at 0x100, wr_valid low in cycles 1 and 2
        set_req(2, 1'b0, 20'h00100, 8'd3);
        req = 3'b100;
        run(9, 32'hFFFF_FFF9, 1'b1);
        check("t2_nstrobe", st_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < st_cyc.size()) begin
                check("t2_st_cyc", st_cyc[i], i + 3);
                check("t2_st_addr", st_addr[i], 32'h100 + i);
                check("t2_st_rw", st_rw[i], 0);
                check("t2_st_wdata", st_wd[i], 32'hA003 + i);
            end
        end
        check("t2_nrd", rd_cyc.size(), 0);
        check("t2_grant_c1", gr_log[1], 32'h4);
        check("t2_ndone", dn_cyc.size(), 1);
        if (dn_cyc.size() > 0) begin
            check("t2_done_cyc", dn_cyc[0], 6);
            check("t2_done_vec", dn_vec[0], 32'h4);
        end

        // T3: all three held high, len 1 each
        set_req(0, 1'b1, 20'h00200, 8'd1);
        set_req(1, 1'b1, 20'h00300, 8'd1);
        set_req(2, 1'b1, 20'h00400, 8'd1);
        req = 3'b111;
        run(16, 32'h0, 1'b0);
        req = 3'b000;
        check("t3_ndone", dn_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < dn_cyc.size()) begin
                logic [31:0] ev;
                logic [31:0] ea;
`ifdef DMA_SCHED_FIXED_PRIO_EN
                ev = 32'h1;
                ea = 32'h200;
`else
                ev = (i == 1) ? 32'h2 : ((i == 2) ? 32'h4 : 32'h1);
                ea = (i == 1) ? 32'h300 : ((i == 2) ? 32'h400 : 32'h200);
`endif
                check("t3_done_cyc", dn_cyc[i], 4 * i + 3);
                check("t3_done_vec", dn_vec[i], ev);
                if (i < st_addr.size()) check("t3_st_addr", st_addr[i], ea);
            end
        end
        @(posedge clk); @(posedge clk); #1;

        // T4a: address wrap
        set_req(1, 1'b1, 20'hFFFFE, 8'd4);
        req = 3'b010;
        run(9, 32'h0, 1'b1);
        check("t4_nstrobe", st_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < st_cyc.size()) begin
                logic [31:0] ea;
                ea = (i == 0) ? 32'hFFFFE : ((i == 1) ? 32'hFFFFF : 32'(i - 2));
                check("t4_st_addr", st_addr[i], ea);
            end
            if (i < rd_dat.size()) begin
                logic [31:0] ed;
                ed = (i == 0) ? 32'hFFFE : ((i == 1) ? 32'hFFFF : 32'(i - 2));
                check("t4_rd_data", rd_dat[i], ed);
                check("t4_rd_id", rd_idq[i], 1);
            end
        end
        if (dn_cyc.size() > 0) check("t4_done_cyc", dn_cyc[0], 6);
        else check("t4_ndone", dn_cyc.size(), 1);

        // T4b: zero length
        set_req(1, 1'b1, 20'h00123, 8'd0);
        req = 3'b010;
        run(5, 32'h0, 1'b1);
        check("t4z_nstrobe", st_cyc.size(), 0);
        check("t4z_ndone", dn_cyc.size(), 1);
        if (dn_cyc.size() > 0) begin
            check("t4z_done_cyc", dn_cyc[0], 1);
            check("t4z_done_vec", dn_vec[0], 32'h2);
        end

        // T5: reset during the third read of a len 8 burst
        set_req(0, 1'b1, 20'h00500, 8'd8);
        req = 3'b001;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
        end
        check("t5_pre_mem_en", 32'(mem_en), 32'h1);
        check("t5_pre_addr", 32'(mem_addr), 32'h502);
        #1 rst_n = 1'b0;
        #1;
        check("t5_grant", 32'(grant), 32'h0);
        check("t5_mem_en", 32'(mem_en), 32'h0);
        check("t5_mem_addr", 32'(mem_addr), 32'h0);
        check("t5_mem_rw", 32'(mem_rw), 32'h0);
        check("t5_rd_valid", 32'(rd_valid), 32'h0);
        check("t5_rd_data", 32'(rd_data), 32'h0);
        check("t5_rd_id", 32'(rd_id), 32'h0);
        check("t5_done", 32'(done), 32'h0);
        begin
            logic [NR-1:0] seen;
            seen = '0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                seen = seen | done;
            end
            check("t5_no_done", 32'(seen), 32'h0);
        end
        set_req(0, 1'b1, 20'h00500, 8'd1);
        set_req(1, 1'b1, 20'h00600, 8'd1);
        set_req(2, 1'b1, 20'h00700, 8'd1);
        req = 3'b111;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_next_grant", 32'(grant), 32'h1);
        check("t5_next_addr", 32'(mem_addr), 32'h500);
        req = 3'b000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
